// File: rtl/ultrasonic_ranger_array_if.sv
// ultrasonic_ranger_array_if: enable/echo inputs and per-channel ranging results of the ranger array.
interface ultrasonic_ranger_array_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W = 32
);
   logic enable;
   logic [CHANNELS-1:0] echo;
   logic [CHANNELS-1:0] trigger;
   logic [CHANNELS*CNT_W-1:0] distance;
   logic [CHANNELS-1:0] timeout;
   logic [CHANNELS-1:0] crash;
   logic any_crash;
   logic sample_valid;
   logic [2:0] sample_ch;
   modport master (output enable, echo, input trigger, distance, timeout, crash, any_crash, sample_valid, sample_ch);
   modport slave (input enable, echo, output trigger, distance, timeout, crash, any_crash, sample_valid, sample_ch);
endinterface

// File: rtl/ultrasonic_ranger_array.sv
// ultrasonic_ranger_array: round-robin ultrasonic ranging with echo timeout and crash hysteresis.
module ultrasonic_ranger_array #(
   parameter int CHANNELS = 2,
   parameter int CNT_W = 32,
   parameter int TRIG_CYCLES = 1000,
   parameter int TIMEOUT_CYCLES = 3800000,
   parameter int HOLDOFF_CYCLES = 6000000,
   parameter int CRASH_THRESH = 294117,
   parameter int HYST = 10000
) (
   input logic clk,
   input logic rst,
   ultrasonic_ranger_array_if.slave bus
);
   localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [CHANNELS-1:0] sync1_q, sync2_q, echo_q, rise, fall;
   logic [CHANNELS-1:0] timeout_q, timeout_d, crash_q, crash_d;
   logic [CHANNELS*CNT_W-1:0] dist_q, dist_d;
   logic any_crash_q, sample_valid_q, res_v, res_to;
   logic [2:0] sample_ch_q;
   logic [CNT_W:0] clear_lvl;
   assign rise = sync2_q & ~echo_q;
   assign fall = ~sync2_q & echo_q;
   assign clear_lvl = (CNT_W+1)'(CRASH_THRESH) + (CNT_W+1)'(HYST);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      ch_d = ch_q;
      res_v = 1'b0;
      res_to = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            state_d = bus.enable ? TRIG : IDLE;
         end
         TRIG: if (cnt_q == CNT_W'(TRIG_CYCLES-1)) begin
            cnt_d = '0;
            state_d = WAIT_RISE;
         end
         WAIT_RISE: if (rise[ch_q]) begin
            cnt_d = CNT_W'(1);
            state_d = MEASURE;
         end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
            res_v = 1'b1;
            res_to = 1'b1;
         end
         MEASURE: begin
            res_v = fall[ch_q] || cnt_q == CNT_W'(TIMEOUT_CYCLES);
            res_to = !fall[ch_q];
         end
         HOLDOFF: if (cnt_q == CNT_W'(HOLDOFF_CYCLES-1)) begin
            cnt_d = '0;
            state_d = IDLE;
            ch_d = (ch_q == CH_W'(CHANNELS-1)) ? '0 : ch_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (res_v) begin
         state_d = HOLDOFF;
         cnt_d = '0;
      end
   end
   // only the active channel's result slot is touched; crash holds inside the hysteresis band
   always_comb begin
      dist_d = dist_q;
      timeout_d = timeout_q;
      crash_d = crash_q;
      if (res_v) begin
         dist_d[ch_q*CNT_W +: CNT_W] = res_to ? CNT_W'(TIMEOUT_CYCLES) : cnt_q;
         timeout_d[ch_q] = res_to;
         crash_d[ch_q] = !res_to && (cnt_q <= CNT_W'(CRASH_THRESH) || (crash_q[ch_q] && {1'b0, cnt_q} <= clear_lvl));
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ch_q <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         echo_q <= '0;
         dist_q <= '0;
         timeout_q <= '0;
         crash_q <= '0;
         any_crash_q <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_ch_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ch_q <= ch_d;
         sync1_q <= bus.echo;
         sync2_q <= sync1_q;
         echo_q <= sync2_q;
         dist_q <= dist_d;
         timeout_q <= timeout_d;
         crash_q <= crash_d;
         any_crash_q <= |crash_d;
         sample_valid_q <= res_v;
         sample_ch_q <= res_v ? 3'(ch_q) : sample_ch_q;
      end
   end
   assign bus.trigger = (state_q == TRIG) ? CHANNELS'(1) << ch_q : '0;
   assign bus.distance = dist_q;
   assign bus.timeout = timeout_q;
   assign bus.crash = crash_q;
   assign bus.any_crash = any_crash_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.sample_ch = sample_ch_q;
endmodule

// File: tb/tb_ultrasonic_ranger_array.sv
// tb_ultrasonic_ranger_array: directed and random pings against a per-ping result model.
module tb_ultrasonic_ranger_array;
   localparam int CH = 2, W = 32, TRIG = 10, TO = 200, HOLD = 20, TH = 50, HY = 10;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ultrasonic_ranger_array_if #(.CHANNELS(CH), .CNT_W(W)) bus ();
   ultrasonic_ranger_array #(
      .CHANNELS(CH), .CNT_W(W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO),
      .HOLDOFF_CYCLES(HOLD), .CRASH_THRESH(TH), .HYST(HY)
   ) dut (.clk(clk), .rst(rst), .bus(bus));
   int total = 0, passed = 0, failed = 0;
   int m_ch;
   logic [W-1:0] m_dist [CH];
   logic m_to [CH];
   logic m_crash [CH];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic reset_model();
      m_ch = 0;
      for (int i = 0; i < CH; i++) begin
         m_dist[i] = '0;
         m_to[i] = 1'b0;
         m_crash[i] = 1'b0;
      end
   endtask
   task automatic check_results(input string tag);
      logic [CH*W-1:0] dv;
      logic [CH-1:0] tv, cv;
      for (int i = 0; i < CH; i++) begin
         dv[i*W +: W] = m_dist[i];
         tv[i] = m_to[i];
         cv[i] = m_crash[i];
      end
      chk({tag, "_distance"}, bus.distance, dv);
      chk({tag, "_timeout"}, bus.timeout, tv);
      chk({tag, "_crash"}, bus.crash, cv);
      chk({tag, "_any_crash"}, bus.any_crash, |cv);
   endtask
   // mode 0: echo pulse of w cycles after dly; 1: echo never rises; 2: echo rises after dly and stays high; 3: echo already high before trigger
   task automatic ping(input int mode, input int dly, input int w);
      int n, k;
      logic oh;
      logic [CH-1:0] pat;
      pat = CH'(1) << m_ch;
      if (mode == 3) bus.echo[m_ch] = 1'b1;
      k = 0;
      while (bus.trigger == '0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("trig_channel", bus.trigger, pat);
      n = 0;
      oh = 1'b1;
      while (bus.trigger != '0 && n < 50) begin
         if (bus.trigger !== pat) oh = 1'b0;
         n++;
         @(negedge clk);
      end
      chk("trig_length", n, TRIG);
      chk("trig_onehot", oh, 1);
      if (mode == 0 || mode == 2) begin
         repeat (dly) @(negedge clk);
         bus.echo[m_ch] = 1'b1;
      end
      if (mode == 0) begin
         repeat (w) @(negedge clk);
         bus.echo[m_ch] = 1'b0;
      end
      k = 0;
      while (!bus.sample_valid && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("sample_valid_seen", k < 600, 1);
      if (mode == 1 || mode == 3) chk("timeout_latency", k, TO);
      bus.echo[m_ch] = 1'b0;
      if (mode != 0) begin
         m_dist[m_ch] = W'(TO);
         m_to[m_ch] = 1'b1;
         m_crash[m_ch] = 1'b0;
      end else begin
         m_dist[m_ch] = W'(w);
         m_to[m_ch] = 1'b0;
         if (w <= TH) m_crash[m_ch] = 1'b1;
         else if (w > TH + HY) m_crash[m_ch] = 1'b0;
      end
      chk("sample_ch", bus.sample_ch, m_ch);
      check_results("ping");
      @(negedge clk);
      chk("sample_valid_pulse", bus.sample_valid, 0);
      m_ch = (m_ch + 1) % CH;
   endtask
   initial begin
      int r, k;
      logic rose;
      bus.enable = 1'b0;
      bus.echo = '0;
      reset_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_trigger", bus.trigger, 0);
      chk("reset_sample_valid", bus.sample_valid, 0);
      chk("reset_sample_ch", bus.sample_ch, 0);
      check_results("reset");
      rose = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.trigger != '0) rose = 1'b1;
      end
      chk("disabled_no_trigger", rose, 0);
      check_results("disabled");
      bus.enable = 1'b1;
      ping(0, 15, 40);
      ping(1, 0, 0);
      ping(0, 15, 55);
      ping(0, 20, 30);
      ping(0, 15, 61);
      ping(3, 0, 0);
      ping(0, 15, 45);
      ping(2, 10, 0);
      for (int i = 0; i < 7; i++) begin
         r = $urandom_range(0, 9);
         ping(r == 0 ? 1 : r == 1 ? 2 : r == 2 ? 3 : 0, $urandom_range(1, 150),
              r < 6 ? $urandom_range(40, 70) : $urandom_range(1, 190));
      end
      k = 0;
      while (bus.trigger == '0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("pre_reset_channel", bus.trigger, CH'(1) << m_ch);
      k = 0;
      while (bus.trigger != '0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      bus.echo[m_ch] = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      reset_model();
      chk("midreset_trigger", bus.trigger, 0);
      chk("midreset_sample_valid", bus.sample_valid, 0);
      chk("midreset_sample_ch", bus.sample_ch, 0);
      check_results("midreset");
      bus.echo = '0;
      rst = 1'b0;
      ping(0, 15, 30);
      bus.enable = 1'b0;
      rose = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.trigger != '0) rose = 1'b1;
      end
      chk("enable_off_no_trigger", rose, 0);
      check_results("enable_off");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ultrasonic_ranger_array.md
# ultrasonic_ranger_array

Multi-channel ultrasonic ranging controller for HC-SR04-class sensors on the rover's 100 MHz fabric clock. It fires sensors one at a time in round-robin order and measures each echo pulse width in clock cycles. It applies an echo timeout and a crash threshold with hysteresis, then publishes per-channel distance, timeout and crash flags to the motor-control logic. It generalises the single-sensor crash detector with a bounded trigger pulse, timeouts, hysteresis and N channels.

## Interface
- CHANNELS, 2: number of sensors (1..8).
- CNT_W, 32: distance counter width.
- TRIG_CYCLES, 1000: trigger pulse length (10 us at 100 MHz).
- TIMEOUT_CYCLES, 3800000: maximum wait for echo rise, and maximum echo width (38 ms).
- HOLDOFF_CYCLES, 6000000: idle gap after each measurement before the next ping (60 ms).
- CRASH_THRESH, 294117: crash asserts when distance <= this value.
- HYST, 10000: crash clears when distance > CRASH_THRESH + HYST.
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- enable  in  1  run ranging sequence.
- echo  in  CHANNELS  raw, asynchronous echo inputs.
- trigger  out  CHANNELS  sensor trigger outputs; at most one bit high.
- distance  out  CHANNELS*CNT_W  last echo width per channel; channel k at [k*CNT_W +: CNT_W].
- timeout  out  CHANNELS  last measurement of channel k timed out.
- crash  out  CHANNELS  per-channel crash flag, with hysteresis.
- any_crash  out  1  OR of crash.
- sample_valid  out  1  one-cycle pulse when a channel result updates.
- sample_ch  out  3  channel index of the current/last result.

## Operation
- Each echo bit passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its registered copy.
- FSM: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF. The active channel is ch, reset value 0.
- IDLE: when enable=1, clear the counter and go to TRIG.
- TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with the counter cleared.
- WAIT_RISE: requires a synchronized rising edge; an echo already high on entry does not count.
  - On a rising edge: count=1, go to MEASURE.
  - If the counter reaches TIMEOUT_CYCLES first: timeout result.
- MEASURE: count +1 per cycle while the synchronized echo is high.
  - On a falling edge: latch count, giving a normal result. An echo high N cycles yields distance N.
  - If count reaches TIMEOUT_CYCLES: timeout result.
- Normal result:
  - distance[ch]=count, timeout[ch]=0.
  - crash[ch] set if count <= CRASH_THRESH.
  - crash[ch] cleared if count > CRASH_THRESH+HYST; otherwise crash[ch] holds.
- Timeout result: distance[ch]=TIMEOUT_CYCLES, timeout[ch]=1, crash[ch]=0 (no object).
- Either result: sample_valid=1 for one cycle, sample_ch=ch, go to HOLDOFF.
- HOLDOFF: wait HOLDOFF_CYCLES. Then ch advances (CHANNELS-1 wraps to 0) and the FSM returns to IDLE.
- enable deasserted mid-sequence: the current measurement and holdoff complete, then the FSM stays in IDLE. Results are retained.
- Other channels' results are never modified by a measurement.
- Arithmetic: the counter saturates at TIMEOUT_CYCLES and never wraps. The comparison CRASH_THRESH+HYST is computed at CNT_W+1 bits.

## Timing
- Reset values: trigger=0, distance=0, timeout=0, crash=0, any_crash=0, sample_valid=0, sample_ch=0, state IDLE, ch=0, synchronizers 0.
- Reset mid-operation: all of the above apply on the next edge. trigger drops immediately.
- The first trigger rises one cycle after enable is sampled high in IDLE.
- The echo path has 2-cycle synchronizer latency plus 1-cycle edge detection. The same latency applies to both edges, so width is preserved.
- The result registers and sample_valid update the cycle after the falling edge is detected. any_crash is registered with crash.
- Ping period per channel = TRIG_CYCLES + wait + width + 1 + HOLDOFF_CYCLES, times CHANNELS.
- A rising and falling edge can never be seen in the same cycle, because they come from the synchronized single bit.

## Test plan
- Parameters: CHANNELS=2, TRIG_CYCLES=10, TIMEOUT_CYCLES=200, HOLDOFF_CYCLES=20, CRASH_THRESH=50, HYST=10.
- Reset, then enable=0 for 100 cycles -> all outputs 0, trigger never rises.
- enable=1; ch0 echo rises 15 cycles after trigger falls and stays high 40 cycles -> trigger[0] high exactly 10 cycles; sample_valid pulse with sample_ch=0; distance0=40, crash0=1, any_crash=1, timeout0=0.
- Hysteresis on ch0, successive widths 40, 55, 61, 45 -> crash0 = 1, 1, 0, 1.
- ch1 echo never rises -> 200 cycles after trigger falls: timeout1=1, distance1=200, crash1=0; ch0 results unchanged.
- Echo stuck high through trigger, and separately echo held high 300 cycles -> both produce timeout=1, distance=200; counter does not wrap.
- Round-robin over 6 pings -> trigger order 0,1,0,1,0,1, never two bits high. Assert rst in MEASURE -> next cycle all outputs 0, ch=0, and the sequence restarts at ch0.
